serial_addsub_nbit: RTL and testbench

- Parametrised bit-serial adder/subtractor.
- Processes one bit per clock, LSB first, through a single full-adder cell and a registered carry.
- Successor to the 1-bit combinational full adder: arbitrary operand width, add/subtract mode, carry-in, signed-overflow flag, start/busy/done handshake.
- Used where area matters more than latency, e.g. lab datapaths and serial ALU slices.

---
 rtl/serial_addsub_nbit_if.sv | 25 ++
 rtl/serial_addsub_nbit.sv | 99 +++++++++
 tb/tb_serial_addsub_nbit.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_addsub_nbit_if.sv
// rtl/serial_addsub_nbit_if.sv - operand/result bundle for the bit-serial adder/subtractor
interface serial_addsub_nbit_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             sub;
    logic             cin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    modport master (
        output start, sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/serial_addsub_nbit.sv
// rtl/serial_addsub_nbit.sv - bit-serial adder/subtractor, one bit per clock, LSB first
module serial_addsub_nbit #(
    parameter int WIDTH = 8,
    localparam int CW = $clog2(WIDTH + 1)
) (
    input logic                 clk,
    input logic                 rst_n,
    serial_addsub_nbit_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] sum_r;
    logic             cout_r;
    logic             ovf_r;

    logic             bit_s;
    logic             carry_next;
    logic             last_step;
    logic             accept;

    // Single full-adder cell fed by the shift-register LSBs and the carry register
    always_comb begin
        bit_s      = a_sr[0] ^ b_sr[0] ^ carry;
        carry_next = (a_sr[0] & b_sr[0]) | (a_sr[0] & carry) | (b_sr[0] & carry);
        last_step  = (cnt == CW'(WIDTH - 1));
        accept     = bus.start && (state == IDLE || state == FIN);
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.sum  = sum_r;
    assign bus.cout = cout_r;
    assign bus.ovf  = ovf_r;

    // Control FSM plus datapath; FIN accepts a new start so back-to-back ops have no gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            sum_r  <= '0;
            cout_r <= 1'b0;
            ovf_r  <= 1'b0;
        end else begin
            case (state)
                IDLE, FIN: begin
                    done_r <= 1'b0;
                    if (accept) begin
                        // Subtraction is a + ~b + 1, so invert b here and force carry-in high
                        a_sr   <= bus.a;
                        b_sr   <= bus.sub ? ~bus.b : bus.b;
                        carry  <= bus.sub | bus.cin;
                        cnt    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        busy_r <= 1'b0;
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    res_sr <= {bit_s, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= carry_next;
                    cnt    <= cnt + 1'b1;
                    if (last_step) begin
                        // carry currently holds the carry into the MSB; compare with carry out
                        sum_r  <= {bit_s, res_sr[WIDTH-1:1]};
                        cout_r <= carry_next;
                        ovf_r  <= carry ^ carry_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= FIN;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_addsub_nbit.sv
// tb/tb_serial_addsub_nbit.sv - self-checking bench for serial_addsub_nbit at WIDTH 2, 8 and 16
module tb_serial_addsub_nbit;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    serial_addsub_nbit_if #(.WIDTH(8))  i8();
    serial_addsub_nbit_if #(.WIDTH(2))  i2();
    serial_addsub_nbit_if #(.WIDTH(16)) i16();

    serial_addsub_nbit #(.WIDTH(8))  u8  (.clk(clk), .rst_n(rst_n), .bus(i8.slave));
    serial_addsub_nbit #(.WIDTH(2))  u2  (.clk(clk), .rst_n(rst_n), .bus(i2.slave));
    serial_addsub_nbit #(.WIDTH(16)) u16 (.clk(clk), .rst_n(rst_n), .bus(i16.slave));

    logic [7:0] opa [4] = '{8'h12, 8'hF0, 8'h7F, 8'hC3};
    logic [7:0] opb [4] = '{8'h34, 8'h0F, 8'h01, 8'h11};
    logic       ops [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic       opc [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain modular arithmetic; overflow from operand/result sign rule
    task automatic ref_model(input int w, input logic [63:0] av, input logic [63:0] bv,
                             input logic sv, input logic cv,
                             output logic [63:0] s, output logic co, output logic ov);
        logic [64:0] mask;
        logic [64:0] bb;
        logic [64:0] total;
        mask  = (65'd1 << w) - 65'd1;
        bb    = sv ? (~{1'b0, bv} & mask) : ({1'b0, bv} & mask);
        total = ({1'b0, av} & mask) + bb + {64'd0, (sv | cv)};
        s     = total[63:0] & mask[63:0];
        co    = total[w];
        ov    = (av[w-1] == bb[w-1]) && (s[w-1] != av[w-1]);
    endtask

    task automatic op8(input logic [7:0] av, input logic [7:0] bv, input logic sv,
                       input logic cv, input bit disturb);
        logic [63:0] es;
        logic        eco;
        logic        eov;
        int          n;
        int          nb;
        ref_model(8, {56'd0, av}, {56'd0, bv}, sv, cv, es, eco, eov);
        @(negedge clk);
        i8.a = av; i8.b = bv; i8.sub = sv; i8.cin = cv; i8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i8.start = 1'b0;
        n = 1;
        nb = 0;
        while (!i8.done && n < 40) begin
            if (i8.busy) nb++;
            if (disturb && n == 3) begin
                i8.start = 1'b1; i8.a = 8'h01; i8.b = 8'h01; i8.sub = ~sv; i8.cin = ~cv;
            end
            if (disturb && n == 4) begin
                i8.start = 1'b0; i8.a = 8'($urandom); i8.b = 8'($urandom);
            end
            @(negedge clk);
            n++;
        end
        chk("latency8", 64'(n), 64'd9);
        chk("busy_cycles8", 64'(nb), 64'd8);
        chk("sum8", {56'd0, i8.sum}, es);
        chk("cout8", {63'd0, i8.cout}, {63'd0, eco});
        chk("ovf8", {63'd0, i8.ovf}, {63'd0, eov});
        chk("busy_at_done8", {63'd0, i8.busy}, 64'd0);
        @(negedge clk);
        chk("done_pulse8", {63'd0, i8.done}, 64'd0);
        chk("sum_hold8", {56'd0, i8.sum}, es);
    endtask

    task automatic op_w(input int w, input logic [15:0] av, input logic [15:0] bv,
                        input logic sv, input logic cv);
        logic [63:0] es;
        logic        eco;
        logic        eov;
        logic [63:0] got_s;
        logic        got_c;
        logic        got_o;
        logic        d;
        int          n;
        ref_model(w, {48'd0, av}, {48'd0, bv}, sv, cv, es, eco, eov);
        @(negedge clk);
        if (w == 2) begin
            i2.a = av[1:0]; i2.b = bv[1:0]; i2.sub = sv; i2.cin = cv; i2.start = 1'b1;
        end else begin
            i16.a = av; i16.b = bv; i16.sub = sv; i16.cin = cv; i16.start = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        i2.start = 1'b0;
        i16.start = 1'b0;
        n = 1;
        d = (w == 2) ? i2.done : i16.done;
        while (!d && n < 40) begin
            @(negedge clk);
            n++;
            d = (w == 2) ? i2.done : i16.done;
        end
        got_s = (w == 2) ? {62'd0, i2.sum} : {48'd0, i16.sum};
        got_c = (w == 2) ? i2.cout : i16.cout;
        got_o = (w == 2) ? i2.ovf : i16.ovf;
        chk($sformatf("latency_w%0d", w), 64'(n), 64'(w + 1));
        chk($sformatf("sum_w%0d", w), got_s, es);
        chk($sformatf("cout_w%0d", w), {63'd0, got_c}, {63'd0, eco});
        chk($sformatf("ovf_w%0d", w), {63'd0, got_o}, {63'd0, eov});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] es;
        logic [63:0] hold;
        logic        eco;
        logic        eov;
        int          cyc;
        int          last;
        int          j;
        bit          have;
        bit          seen;

        i8.start = 0;  i8.sub = 0;  i8.cin = 0;  i8.a = '0;  i8.b = '0;
        i2.start = 0;  i2.sub = 0;  i2.cin = 0;  i2.a = '0;  i2.b = '0;
        i16.start = 0; i16.sub = 0; i16.cin = 0; i16.a = '0; i16.b = '0;
        repeat (3) @(negedge clk);
        chk("rst_sum", {56'd0, i8.sum}, 64'd0);
        chk("rst_busy", {63'd0, i8.busy}, 64'd0);
        chk("rst_done", {63'd0, i8.done}, 64'd0);
        chk("rst_cout_ovf", {62'd0, i8.cout, i8.ovf}, 64'd0);
        rst_n = 1'b1;

        // Directed cases
        op8(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
        op8(8'h10, 8'h20, 1'b1, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 1'b0, 1'b0);
        op8(8'hFF, 8'h01, 1'b0, 1'b1, 1'b0);
        op8(8'hFF, 8'h01, 1'b1, 1'b1, 1'b0);
        op8(8'h22, 8'h11, 1'b0, 1'b0, 1'b1);

        // Random cases
        for (int k = 0; k < 10; k++)
            op8(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), bit'($urandom));

        // Back-to-back with start held high
        @(negedge clk);
        i8.a = opa[0]; i8.b = opb[0]; i8.sub = ops[0]; i8.cin = opc[0]; i8.start = 1'b1;
        @(posedge clk);
        cyc = 0; last = 0; j = 0; have = 0; hold = '0;
        while (j < 4 && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (i8.done) begin
                ref_model(8, {56'd0, opa[j]}, {56'd0, opb[j]}, ops[j], opc[j], es, eco, eov);
                chk("b2b_sum", {56'd0, i8.sum}, es);
                chk("b2b_cout", {63'd0, i8.cout}, {63'd0, eco});
                chk("b2b_interval", 64'(cyc - last), 64'd9);
                last = cyc; hold = es; have = 1; j++;
                if (j < 4) begin
                    i8.a = opa[j]; i8.b = opb[j]; i8.sub = ops[j]; i8.cin = opc[j];
                end else begin
                    i8.start = 1'b0;
                end
            end else if (have) begin
                chk("b2b_hold", {56'd0, i8.sum}, hold);
            end
        end
        chk("b2b_count", 64'(j), 64'd4);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        i8.a = 8'h5A; i8.b = 8'h3C; i8.sub = 0; i8.cin = 0; i8.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        i8.start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_sum", {56'd0, i8.sum}, 64'd0);
        chk("abort_busy", {63'd0, i8.busy}, 64'd0);
        chk("abort_done", {63'd0, i8.done}, 64'd0);
        chk("abort_cout_ovf", {62'd0, i8.cout, i8.ovf}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (i8.done) seen = 1;
        end
        chk("no_done_after_abort", {63'd0, seen}, 64'd0);
        op8(8'h7F, 8'h01, 1'b0, 1'b0, 1'b0);

        // Other widths
        op_w(2, 16'h0003, 16'h0001, 1'b0, 1'b0);
        op_w(2, 16'h0001, 16'h0002, 1'b1, 1'b0);
        op_w(16, 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        op_w(16, 16'h8000, 16'h0001, 1'b1, 1'b1);
        for (int k = 0; k < 4; k++) begin
            op_w(2, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
            op_w(16, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
